// File: rtl/mux16to1_collect_if.sv
// Purpose: bundles the lane, select, request and response handshake signals
//          of mux16to1_collect.
// Ports:   a0..a15 (N-bit result lanes), a_vld (per-lane valid), fn_sel (lane
//          select, 16..31 illegal), req (collect request), busy, out, out_vld,
//          out_rdy, err.
//          The master modport is the side that issues requests and consumes
//          results. The slave modport is the collector.
interface mux16to1_collect_if #(
  parameter int unsigned N = 16
);
  logic [N-1:0] a0;
  logic [N-1:0] a1;
  logic [N-1:0] a2;
  logic [N-1:0] a3;
  logic [N-1:0] a4;
  logic [N-1:0] a5;
  logic [N-1:0] a6;
  logic [N-1:0] a7;
  logic [N-1:0] a8;
  logic [N-1:0] a9;
  logic [N-1:0] a10;
  logic [N-1:0] a11;
  logic [N-1:0] a12;
  logic [N-1:0] a13;
  logic [N-1:0] a14;
  logic [N-1:0] a15;
  logic [15:0]  a_vld;
  logic [4:0]   fn_sel;
  logic         req;
  logic         busy;
  logic [N-1:0] out;
  logic         out_vld;
  logic         out_rdy;
  logic         err;

  modport master (
    output a0, a1, a2, a3, a4, a5, a6, a7,
           a8, a9, a10, a11, a12, a13, a14, a15,
           a_vld, fn_sel, req, out_rdy,
    input  busy, out, out_vld, err
  );

  modport slave (
    input  a0, a1, a2, a3, a4, a5, a6, a7,
           a8, a9, a10, a11, a12, a13, a14, a15,
           a_vld, fn_sel, req, out_rdy,
    output busy, out, out_vld, err
  );
endinterface

// File: rtl/mux16to1_collect.sv
// Purpose: collects one result from one of 16 function-unit lanes.
//          A request in IDLE latches the lane select. The block then waits,
//          for a bounded time, until that lane reports valid.
//          The result is held until the consumer accepts it.
//          An illegal select or a timeout returns an error response with out=0.
// Ports:   clk, rst_n (async active-low).
//          bus (slave modport): lanes a0..a15, a_vld, fn_sel, req and out_rdy
//          in; busy, out, out_vld and err out, all registered.
module mux16to1_collect #(
  parameter int unsigned N       = 16,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  mux16to1_collect_if.slave bus
);

  localparam int unsigned LANES = 16;
  localparam int unsigned SEL_W = 4;
  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t           r_state;
  logic [SEL_W-1:0] r_sel_q;
  logic [CNT_W-1:0] r_cnt;
  logic [N-1:0]     r_out;
  logic             r_out_vld;
  logic             r_err;
  logic             r_busy;

  logic [N-1:0]     w_lane [LANES];
  logic [N-1:0]     w_sel_data;
  logic             w_sel_vld;
  logic             w_sel_legal;

  // Lanes gathered into an array so the latched select can index them.
  assign w_lane[0]  = bus.a0;
  assign w_lane[1]  = bus.a1;
  assign w_lane[2]  = bus.a2;
  assign w_lane[3]  = bus.a3;
  assign w_lane[4]  = bus.a4;
  assign w_lane[5]  = bus.a5;
  assign w_lane[6]  = bus.a6;
  assign w_lane[7]  = bus.a7;
  assign w_lane[8]  = bus.a8;
  assign w_lane[9]  = bus.a9;
  assign w_lane[10] = bus.a10;
  assign w_lane[11] = bus.a11;
  assign w_lane[12] = bus.a12;
  assign w_lane[13] = bus.a13;
  assign w_lane[14] = bus.a14;
  assign w_lane[15] = bus.a15;

  // Only the latched lane is observed in WAIT; other valid bits are ignored.
  assign w_sel_data  = w_lane[r_sel_q];
  assign w_sel_vld   = bus.a_vld[r_sel_q];
  // Selects 16..31 are the ones with the top bit set.
  assign w_sel_legal = ~bus.fn_sel[4];

  // Collect FSM. Every output is a register updated together with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_sel_q   <= '0;
      r_cnt     <= '0;
      r_out     <= '0;
      r_out_vld <= 1'b0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.req) begin
            r_busy <= 1'b1;
            if (w_sel_legal) begin
              r_sel_q <= bus.fn_sel[SEL_W-1:0];
              r_cnt   <= '0;
              r_state <= S_WAIT;
            end else begin
              r_out     <= '0;
              r_err     <= 1'b1;
              r_out_vld <= 1'b1;
              r_state   <= S_HOLD;
            end
          end
        end
        S_WAIT: begin
          // A valid arriving in the last counted cycle beats the timeout.
          if (w_sel_vld) begin
            r_out     <= w_sel_data;
            r_err     <= 1'b0;
            r_out_vld <= 1'b1;
            r_state   <= S_HOLD;
          end else if (r_cnt == CNT_MAX) begin
            r_out     <= '0;
            r_err     <= 1'b1;
            r_out_vld <= 1'b1;
            r_state   <= S_HOLD;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_HOLD: begin
          // On acceptance, out keeps its last value.
          if (bus.out_rdy) begin
            r_out_vld <= 1'b0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_out_vld <= 1'b0;
          r_err     <= 1'b0;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.out     = r_out;
  assign bus.out_vld = r_out_vld;
  assign bus.err     = r_err;
  assign bus.busy    = r_busy;

endmodule

// File: doc/mux16to1_collect.md
MUX16TO1_COLLECT -- requirements
Module: mux16to1_collect

Interface
REQ-001 Parameter N, default 16, width of each data lane and of out.
REQ-002 Parameter TIMEOUT, default 15, count of extra WAIT cycles without unit valid before the error is taken.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset; asynchronous and active-low.
REQ-005 a0..a15  input  N each  result lanes from the 16 function units.
REQ-006 a_vld  input  16  per-lane result valid; bit k qualifies ak.
REQ-007 fn_sel  input  5  lane select, same encoding as the dispatch demux; 16..31 are illegal.
REQ-008 req  input  1  collect request, sampled only in IDLE.
REQ-009 busy  output  1  high whenever state is not IDLE.
REQ-010 out  output  N  registered collected result.
REQ-011 out_vld  output  1  out holds a result or an error response awaiting acceptance.
REQ-012 out_rdy  input  1  consumer accepts out when high together with out_vld.
REQ-013 err  output  1  the current out_vld response is an error (illegal select or timeout); valid only while out_vld is high.

Function
REQ-014 The FSM SHALL have three states: IDLE, WAIT and HOLD.
REQ-015 IDLE with req=1 and fn_sel<16: latch fn_sel into sel_q, clear cnt to 0, and go to WAIT.
REQ-016 IDLE with req=1 and fn_sel>=16: set out=0, err=1 and out_vld=1, and go directly to HOLD.
REQ-017 IDLE with req=0: hold state and all outputs.
REQ-018 WAIT with a_vld[sel_q]=1: register out<=a[sel_q], set err=0 and out_vld=1, and go to HOLD, so out_vld rises 2 edges after the req edge at minimum.
REQ-019 WAIT with a_vld[sel_q]=0 and cnt<TIMEOUT: increment cnt and stay in WAIT.
REQ-020 WAIT with a_vld[sel_q]=0 and cnt==TIMEOUT: set out=0, err=1 and out_vld=1, and go to HOLD, so WAIT lasts at most TIMEOUT+1 cycles.
REQ-021 If a_vld[sel_q] rises in the same cycle that cnt reaches TIMEOUT, the valid SHALL win and no error is raised.
REQ-022 Only lane sel_q SHALL be observed in WAIT; a_vld bits of other lanes are ignored.
REQ-023 Changes on fn_sel after the latching edge SHALL have no effect until the next IDLE.
REQ-024 HOLD: out, err and out_vld SHALL stay stable until an edge with out_rdy=1; on that edge out_vld<=0, err<=0, and state goes to IDLE.
REQ-025 After acceptance, out SHALL retain its last value.
REQ-026 out_rdy high outside HOLD SHALL have no effect.
REQ-027 req while busy=1 SHALL be ignored and not queued.
REQ-028 The first req SHALL be sampled in the IDLE cycle after a HOLD acceptance, so there is a minimum of 1 IDLE cycle between transactions.
REQ-029 cnt SHALL be ceil(log2(TIMEOUT+1)) bits wide and SHALL never wrap.

Reset
REQ-030 rst_n low SHALL force, asynchronously: state=IDLE, out=0, out_vld=0, err=0, busy=0, sel_q=0, cnt=0.
REQ-031 Reset asserted mid-WAIT or mid-HOLD SHALL abandon the transaction with no out_vld pulse.
REQ-032 Operation SHALL resume on the first rising edge after rst_n deasserts.

Verification
REQ-033 Normal path: fn_sel=3, req=1 for 1 cycle, a3=16'hBEEF, a_vld[3]=1 already high, out_rdy=1 -> out_vld high exactly 2 edges after req, out=16'hBEEF, err=0, then IDLE.
REQ-034 Backpressure: fn_sel=15, a15=16'h1234 valid, out_rdy=0 for 5 cycles -> out=16'h1234 and out_vld held stable for 5 cycles; a15 changed to 16'h0 meanwhile does not alter out; one-cycle acceptance when out_rdy rises.
REQ-035 Timeout: fn_sel=7, a_vld=0 -> exactly 16 WAIT cycles, then out_vld=1, err=1, out=0; a second run with a_vld[7] raised on the 16th WAIT cycle -> err=0 and out=a7.
REQ-036 Illegal select: fn_sel=20, req=1 -> out_vld=1, err=1, out=0 one edge after req, with no WAIT state.
REQ-037 Mid-operation control: req pulses and fn_sel changes during WAIT/HOLD are ignored; rst_n pulse low in WAIT -> immediate out_vld=0, busy=0, and no response after release.
REQ-038 Lane sweep: for k=0..15 with random ak and only a_vld[k]=1 -> each out equals ak; a_vld[j], j!=k, high alone never completes the transaction.
